// File: rtl/pf_ddr4_dqs_dly_trainer.sv
// Read-DQS delay-line trainer: sweeps the IOD RX delay tap by tap, finds the passing eye window, then centres the delay.
// Optional DQS_TRAIN_MIN_WINDOW_EN rejects passing windows narrower than MIN_WINDOW taps.
module pf_ddr4_dqs_dly_trainer #(
  parameter int MAX_TAPS      = 128,
  parameter int TAP_W         = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 8
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [TAP_W-1:0] TAP,
  output logic [TAP_W-1:0] WIN_START,
  output logic [TAP_W-1:0] WIN_END
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_CLEAR, ST_SAMPLE,
    ST_EVAL, ST_STEP, ST_CENTER, ST_DONE, ST_FAIL
  } state_t;

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);

`ifdef DQS_TRAIN_MIN_WINDOW_EN
  localparam int MIN_W_INT = MIN_WINDOW;
`else
  // A minimum width of one tap accepts every window.
  localparam int MIN_W_INT = 1 + 0 * MIN_WINDOW;
`endif
  localparam logic [TAP_W:0] MIN_W = (TAP_W + 1)'(MIN_W_INT);

  state_t           state;
  logic             found;
  logic             bad;
  logic             center_wait;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W:0]   win_sum;
  logic [TAP_W:0]   close_width;
  logic [TAP_W:0]   open_width;
  logic [TAP_W-1:0] open_start;
  logic [TAP_W-1:0] target;
  logic             oor_hit;

  // Open window at the last tap may have been found in this very EVAL cycle.
  always_comb begin
    win_sum     = {1'b0, WIN_START} + {1'b0, WIN_END};
    target      = TAP_W'(win_sum >> 1);
    close_width = {1'b0, TAP} - {1'b0, WIN_START};
    open_start  = found ? WIN_START : TAP;
    open_width  = {1'b0, LAST_TAP} - {1'b0, open_start} + (TAP_W + 1)'(1);
    oor_hit     = DELAY_LINE_OUT_OF_RANGE &&
                  (state inside {ST_CLEAR, ST_SAMPLE, ST_EVAL, ST_STEP, ST_CENTER});
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state                   <= ST_IDLE;
      found                   <= 1'b0;
      bad                     <= 1'b0;
      center_wait             <= 1'b0;
      cnt                     <= '0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      ERROR                   <= 1'b0;
      TAP                     <= '0;
      WIN_START               <= '0;
      WIN_END                 <= '0;
    end else begin
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      if (oor_hit) begin
        state <= ST_FAIL;
        BUSY  <= 1'b0;
        ERROR <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START) begin
              state           <= ST_LOAD;
              DELAY_LINE_LOAD <= 1'b1;
              BUSY            <= 1'b1;
              DONE            <= 1'b0;
              ERROR           <= 1'b0;
              WIN_START       <= '0;
              WIN_END         <= '0;
              TAP             <= '0;
              found           <= 1'b0;
            end
          end
          ST_LOAD: begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state                   <= ST_CLEAR;
              EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
              bad                     <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_CLEAR: begin
            state <= ST_SAMPLE;
            cnt   <= '0;
          end
          ST_SAMPLE: begin
            bad <= bad | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
            if (cnt == SAMPLE_LAST) state <= ST_EVAL;
            else cnt <= cnt + 1'b1;
          end
          ST_EVAL: begin
            if (!found && !bad) begin
              WIN_START <= TAP;
              found     <= 1'b1;
            end
            if (found && bad) begin
              WIN_END <= TAP - 1'b1;
              if (close_width < MIN_W) begin
                found <= 1'b0;
                if (TAP == LAST_TAP) begin
                  state <= ST_FAIL;
                  BUSY  <= 1'b0;
                  ERROR <= 1'b1;
                end else begin
                  state                <= ST_STEP;
                  DELAY_LINE_MOVE      <= 1'b1;
                  DELAY_LINE_DIRECTION <= 1'b1;
                  TAP                  <= TAP + 1'b1;
                end
              end else begin
                state       <= ST_CENTER;
                center_wait <= 1'b0;
              end
            end else if (TAP == LAST_TAP) begin
              if ((found || !bad) && open_width >= MIN_W) begin
                WIN_END     <= TAP;
                state       <= ST_CENTER;
                center_wait <= 1'b0;
              end else begin
                state <= ST_FAIL;
                BUSY  <= 1'b0;
                ERROR <= 1'b1;
              end
            end else begin
              state                <= ST_STEP;
              DELAY_LINE_MOVE      <= 1'b1;
              DELAY_LINE_DIRECTION <= 1'b1;
              TAP                  <= TAP + 1'b1;
            end
          end
          ST_STEP: begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
          // Each decrement is a MOVE pulse followed by one idle cycle.
          ST_CENTER: begin
            if (center_wait) begin
              center_wait <= 1'b0;
            end else if (TAP == target) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              DELAY_LINE_MOVE      <= 1'b1;
              DELAY_LINE_DIRECTION <= 1'b0;
              TAP                  <= TAP - 1'b1;
              center_wait          <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pf_ddr4_dqs_dly_trainer.sv
// Bench for pf_ddr4_dqs_dly_trainer: random eyes against a window/timeline model, plus directed fault and reset cases.
module tb_pf_ddr4_dqs_dly_trainer;

  localparam int MAX_TAPS   = 128;
  localparam int TAP_W      = 7;
  localparam int S          = 4;
  localparam int N          = 8;
  localparam int MIN_WINDOW = 8;
  localparam int P          = S + N + 3;
  localparam int E0         = S + N + 3;
`ifdef DQS_TRAIN_MIN_WINDOW_EN
  localparam int MINW = MIN_WINDOW;
`else
  localparam int MINW = 1;
`endif

  logic FAB_CLK, ARST, START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
  logic DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic BUSY, DONE, ERROR;
  logic [TAP_W-1:0] TAP, WIN_START, WIN_END;

  pf_ddr4_dqs_dly_trainer #(
    .MAX_TAPS(MAX_TAPS), .TAP_W(TAP_W), .SETTLE_CYCLES(S),
    .SAMPLE_CYCLES(N), .MIN_WINDOW(MIN_WINDOW)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .START(START),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .TAP(TAP), .WIN_START(WIN_START), .WIN_END(WIN_END)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  bit   eye [0:MAX_TAPS-1];
  int   rs[$];
  int   re[$];
  int   m_cons, m_l, m_d;
  bit   m_pass;
  logic m_prev_dir;
  int   n_checks, n_fail;
  int   n_up, n_dn;
  logic load_first;
  int   iod_tap;
  logic [1:0] flag_rnd;

  // IOD stand-in: follows LOAD/MOVE pulses and flags any tap outside the eye.
  always @(negedge FAB_CLK) begin
    if (ARST || DELAY_LINE_LOAD) iod_tap = 0;
    else if (DELAY_LINE_MOVE) iod_tap = DELAY_LINE_DIRECTION ? iod_tap + 1 : iod_tap - 1;
    if (iod_tap < 0 || iod_tap >= MAX_TAPS || !eye[iod_tap]) begin
      flag_rnd          = 2'($urandom_range(1, 3));
      EYE_MONITOR_EARLY = flag_rnd[0];
      EYE_MONITOR_LATE  = flag_rnd[1];
    end else begin
      EYE_MONITOR_EARLY = 1'b0;
      EYE_MONITOR_LATE  = 1'b0;
    end
  end

  function automatic int e_at(int k);
    return E0 + k * P;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {4'b0, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
            BUSY, DONE, ERROR, TAP, WIN_START, WIN_END};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_eye();
    for (int k = 0; k < MAX_TAPS; k++) eye[k] = 1'b0;
  endtask

  task automatic add_run(input int s, input int e);
    for (int k = s; k <= e; k++) eye[k] = 1'b1;
  endtask

  // Window model: maximal passing runs, first one wide enough is accepted.
  task automatic build_model();
    int e, acc;
    rs.delete();
    re.delete();
    for (int k = 0; k < MAX_TAPS; k++) begin
      if (eye[k] && (k == 0 || !eye[k-1])) begin
        e = k;
        while (e < MAX_TAPS - 1 && eye[e+1]) e++;
        rs.push_back(k);
        re.push_back(e);
      end
    end
    acc = -1;
    for (int i = 0; i < rs.size(); i++)
      if (acc < 0 && re[i] - rs[i] + 1 >= MINW) acc = i;
    m_pass = (acc >= 0);
    m_cons = m_pass ? acc + 1 : rs.size();
    if (m_pass) begin
      m_l = (re[acc] == MAX_TAPS - 1) ? MAX_TAPS - 1 : re[acc] + 1;
      m_d = m_l - ((rs[acc] + re[acc]) >> 1);
    end else begin
      m_l = MAX_TAPS - 1;
      m_d = 0;
    end
  endtask

  // Expected outputs t cycles after the cycle in which START was sampled.
  function automatic logic [31:0] exp_vec(int t);
    int   ws, we, k, j, pulses, tap;
    logic ld, mv, dr, cl, bz, dn, er;
    ws = 0; we = 0; tap = 0;
    for (int i = 0; i < m_cons; i++) begin
      if (t >= e_at(rs[i]) + 1) ws = rs[i];
      if (re[i] < MAX_TAPS - 1 && t >= e_at(re[i] + 1) + 1) we = re[i];
      if (re[i] == MAX_TAPS - 1 && m_pass && i == m_cons - 1 && t >= e_at(MAX_TAPS - 1) + 1) we = re[i];
    end
    ld = (t == 1); mv = 1'b0; cl = 1'b0; dn = 1'b0; er = 1'b0; bz = 1'b1; dr = m_prev_dir;
    if (t <= e_at(m_l)) begin
      k   = (t <= E0) ? 0 : (t - E0 - 1) / P + 1;
      tap = k;
      mv  = (t > E0) && (((t - E0 - 1) % P) == 0);
      dr  = (t > E0) ? 1'b1 : m_prev_dir;
      cl  = (t == e_at(k) - N - 1);
    end else begin
      dr = 1'b1;
      if (m_pass) begin
        j      = t - e_at(m_l) - 1;
        pulses = (j + 1) / 2;
        if (pulses > m_d) pulses = m_d;
        tap = m_l - pulses;
        mv  = (j % 2 == 1) && (j < 2 * m_d);
        if (m_d > 0 && j >= 1) dr = 1'b0;
        bz  = (j <= 2 * m_d);
        dn  = (j >= 2 * m_d + 1);
      end else begin
        tap = m_l;
        bz  = 1'b0;
        er  = 1'b1;
      end
    end
    return {4'b0, ld, mv, dr, cl, bz, dn, er, TAP_W'(tap), TAP_W'(ws), TAP_W'(we)};
  endfunction

  // Starts a training run and compares every cycle; stop_at > 0 ends early.
  task automatic apply_stimulus(input int stop_at);
    int t_end;
    build_model();
    t_end = m_pass ? e_at(m_l) + 1 + 2 * m_d + 2 : e_at(m_l) + 2;
    if (stop_at > 0) t_end = stop_at;
    n_up = 0; n_dn = 0;
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    load_first = DELAY_LINE_LOAD;
    for (int t = 1; t <= t_end; t++) begin
      if (t > 1) @(negedge FAB_CLK);
      check_output($sformatf("cycle %0d", t), dut_vec(), exp_vec(t));
      if (DELAY_LINE_MOVE) begin
        if (DELAY_LINE_DIRECTION) n_up++;
        else n_dn++;
      end
      START = (t > 1 && t < e_at(m_l) && $urandom_range(0, 63) == 0);
    end
    START = 1'b0;
    if (stop_at == 0) m_prev_dir = (m_pass && m_d > 0) ? 1'b0 : 1'b1;
  endtask

  initial begin
    int s, w, nr;
    n_checks = 0; n_fail = 0; m_prev_dir = 1'b0; iod_tap = 0;
    ARST = 1'b1; START = 1'b0; DELAY_LINE_OUT_OF_RANGE = 1'b0;
    EYE_MONITOR_EARLY = 1'b0; EYE_MONITOR_LATE = 1'b0;
    clear_eye();
    repeat (3) @(negedge FAB_CLK);
    check_output("reset outputs", dut_vec(), 32'h0);
    ARST = 1'b0;
    @(negedge FAB_CLK);

    $display("[TB] eye 20..59");
    add_run(20, 59);
    apply_stimulus(0);
    check_output("eye20 up pulses", 32'(n_up), 32'd60);
    check_output("eye20 down pulses", 32'(n_dn), 32'd21);
    check_output("eye20 win_start", 32'(WIN_START), 32'd20);
    check_output("eye20 win_end", 32'(WIN_END), 32'd59);
    check_output("eye20 tap", 32'(TAP), 32'd39);
    check_output("eye20 done/error", {30'b0, DONE, ERROR}, 32'd2);

    $display("[TB] no eye");
    clear_eye();
    apply_stimulus(0);
    check_output("noeye up pulses", 32'(n_up), 32'd127);
    check_output("noeye down pulses", 32'(n_dn), 32'd0);
    check_output("noeye done/error", {30'b0, DONE, ERROR}, 32'd1);
    check_output("noeye tap", 32'(TAP), 32'd127);

    $display("[TB] eye 100..127");
    add_run(100, 127);
    apply_stimulus(0);
    check_output("eye100 win_end", 32'(WIN_END), 32'd127);
    check_output("eye100 down pulses", 32'(n_dn), 32'd14);
    check_output("eye100 tap", 32'(TAP), 32'd113);
    check_output("eye100 done", 32'(DONE), 32'd1);

    $display("[TB] eyes 30..34 and 50..69");
    clear_eye();
    add_run(30, 34);
    add_run(50, 69);
    apply_stimulus(0);
`ifdef DQS_TRAIN_MIN_WINDOW_EN
    check_output("two-eye win_start", 32'(WIN_START), 32'd50);
    check_output("two-eye win_end", 32'(WIN_END), 32'd69);
    check_output("two-eye tap", 32'(TAP), 32'd59);
`else
    check_output("two-eye win_start", 32'(WIN_START), 32'd30);
    check_output("two-eye win_end", 32'(WIN_END), 32'd34);
    check_output("two-eye tap", 32'(TAP), 32'd32);
`endif

    $display("[TB] out-of-range during sample at tap 5");
    clear_eye();
    apply_stimulus(e_at(5) - 3);
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    check_output("oor error", 32'(ERROR), 32'd1);
    check_output("oor busy", 32'(BUSY), 32'd0);
    check_output("oor done", 32'(DONE), 32'd0);
    check_output("oor tap", 32'(TAP), 32'd5);
    n_up = 0;
    repeat (30) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_MOVE || DELAY_LINE_LOAD || EYE_MONITOR_CLEAR_FLAGS) n_up++;
    end
    check_output("oor pulses after fail", 32'(n_up), 32'd0);
    m_prev_dir = 1'b1;
    add_run(20, 59);
    apply_stimulus(0);
    check_output("restart load", 32'(load_first), 32'd1);

    $display("[TB] reset during centring");
    apply_stimulus(e_at(60) + 5);
    ARST = 1'b1;
    #1;
    check_output("async reset outputs", dut_vec(), 32'h0);
    @(negedge FAB_CLK);
    ARST = 1'b0;
    m_prev_dir = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check_output("idle after reset", dut_vec(), 32'h0);
    clear_eye();
    add_run(0, MAX_TAPS - 1);
    apply_stimulus(0);
    check_output("full-eye tap", 32'(TAP), 32'd63);

    $display("[TB] random eyes");
    for (int r = 0; r < 8; r++) begin
      clear_eye();
      nr = $urandom_range(0, 3);
      for (int i = 0; i < nr; i++) begin
        s = $urandom_range(0, MAX_TAPS - 1);
        w = $urandom_range(1, 30);
        add_run(s, (s + w - 1 > MAX_TAPS - 1) ? MAX_TAPS - 1 : s + w - 1);
      end
      apply_stimulus(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
